// File: rtl/div.sv
// Sequential unsigned restoring divider, one quotient bit per cycle, with mul-style handshake.
// Define DIV_ZERO_FLAG_EN to add a registered div_zero flag delivered alongside each result.
module div #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RES_WIDTH  = 64,
    parameter int unsigned CNT_WIDTH  = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rd_en,
    input  logic                  wr_en,
    input  logic [RES_WIDTH-1:0]  wr_dividend,
    input  logic [DATA_WIDTH-1:0] wr_divisor,
    output logic [RES_WIDTH-1:0]  rd_quot,
    output logic [DATA_WIDTH-1:0] rd_rem,
    output logic                  wr_ready,
    output logic                  rd_ready,
    output logic                  rd_val
`ifdef DIV_ZERO_FLAG_EN
    ,
    output logic                  div_zero
`endif
);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e                state_q;
    logic [RES_WIDTH-1:0]  quot_q;
    logic [DATA_WIDTH-1:0] rem_q;
    logic [DATA_WIDTH-1:0] divisor_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
`ifdef DIV_ZERO_FLAG_EN
    logic                  zero_q;
`endif

    logic [DATA_WIDTH:0]   shifted;
    logic                  trial_ok;
    logic [DATA_WIDTH-1:0] rem_step;
    logic [RES_WIDTH-1:0]  quot_step;
    logic                  last_iter;

    // The partial remainder is always below the divisor, so after the shift it
    // fits in DATA_WIDTH+1 bits and the kept difference fits in DATA_WIDTH bits.
    always_comb begin
        shifted   = {rem_q, quot_q[RES_WIDTH-1]};
        trial_ok  = shifted >= {1'b0, divisor_q};
        rem_step  = trial_ok ? DATA_WIDTH'(shifted - {1'b0, divisor_q})
                             : shifted[DATA_WIDTH-1:0];
        quot_step = {quot_q[RES_WIDTH-2:0], trial_ok};
        last_iter = (cnt_q == CNT_WIDTH'(RES_WIDTH - 1));
    end

    assign wr_ready = (state_q == StIdle);
    assign rd_ready = (state_q == StDone);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            quot_q    <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
            cnt_q     <= '0;
            rd_quot   <= '0;
            rd_rem    <= '0;
            rd_val    <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
            zero_q    <= 1'b0;
            div_zero  <= 1'b0;
`endif
        end else begin
            rd_val <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (wr_en) begin
                        divisor_q <= wr_divisor;
                        cnt_q     <= '0;
                        if (wr_divisor == '0) begin
                            quot_q  <= '1;
                            rem_q   <= wr_dividend[DATA_WIDTH-1:0];
                            state_q <= StDone;
`ifdef DIV_ZERO_FLAG_EN
                            zero_q  <= 1'b1;
`endif
                        end else begin
                            quot_q  <= wr_dividend;
                            rem_q   <= '0;
                            state_q <= StCalc;
`ifdef DIV_ZERO_FLAG_EN
                            zero_q  <= 1'b0;
`endif
                        end
                    end
                end
                StCalc: begin
                    quot_q <= quot_step;
                    rem_q  <= rem_step;
                    cnt_q  <= cnt_q + CNT_WIDTH'(1);
                    if (last_iter) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (rd_en) begin
                        rd_quot  <= quot_q;
                        rd_rem   <= rem_q;
                        rd_val   <= 1'b1;
                        state_q  <= StIdle;
`ifdef DIV_ZERO_FLAG_EN
                        div_zero <= zero_q;
`endif
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
